// File: rtl/led_zone_shifter.sv
// rtl/led_zone_shifter.sv - double-buffered zone RAM shifted out to a MiniLED driver chain
module led_zone_shifter #(
    parameter int ZONES   = 512,
    parameter int DATA_W  = 16,
    parameter int CLK_DIV = 4,
    parameter int LATCH_W = 4
) (
    input  logic              sys_clk,
    input  logic              sys_rst,
    input  logic [DATA_W-1:0] light,
    input  logic [8:0]        light_index,
    input  logic              light_refresh,
    input  logic              filter_end,
    output logic              led_sclk,
    output logic              led_sdi,
    output logic              led_latch,
    output logic              busy,
    output logic              frame_drop
);
    localparam int ZW = (ZONES > 1) ? $clog2(ZONES) : 1;
    localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int LW = (LATCH_W > 1) ? $clog2(LATCH_W) : 1;

    localparam logic [ZW-1:0] ZONE_LAST = ZW'(ZONES - 1);
    localparam logic [BW-1:0] BIT_MSB   = BW'(DATA_W - 1);
    localparam logic [DW-1:0] DIV_LAST  = DW'(CLK_DIV - 1);
    localparam logic [LW-1:0] LAT_LAST  = LW'(LATCH_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_LATCH,
        S_DONE
    } state_t;

    // Two banks back to back; the bank select is the top address bit.
    logic [DATA_W-1:0] zone_ram [2**(ZW+1)];
    logic [DATA_W-1:0] ram_rd;
    logic              wr_en;

    state_t            state_q,     state_d;
    logic              wr_bank_q,   wr_bank_d;
    logic              rd_bank_q,   rd_bank_d;
    logic              pending_q,   pending_d;
    logic [ZW-1:0]     zone_q,      zone_d;
    logic [BW-1:0]     bit_idx_q,   bit_idx_d;
    logic [DW-1:0]     div_cnt_q,   div_cnt_d;
    logic [LW-1:0]     lat_cnt_q,   lat_cnt_d;
    logic [DATA_W-1:0] shreg_q,     shreg_d;
    logic              led_sclk_q,  led_sclk_d;
    logic              led_sdi_q,   led_sdi_d;
    logic              led_latch_q, led_latch_d;
    logic              busy_q,      busy_d;
    logic              frame_drop_q, frame_drop_d;

    assign wr_en  = light_refresh && ({23'd0, light_index} < 32'(ZONES));
    assign ram_rd = zone_ram[{rd_bank_q, zone_q}];

    // Zone RAM write port: always targets the bank currently being filled.
    always_ff @(posedge sys_clk) begin
        if (wr_en) begin
            zone_ram[{wr_bank_q, light_index[ZW-1:0]}] <= light;
        end
    end

    // Next-state logic for the frame sequencer and its registered outputs.
    always_comb begin
        state_d      = state_q;
        wr_bank_d    = wr_bank_q;
        rd_bank_d    = rd_bank_q;
        pending_d    = pending_q;
        zone_d       = zone_q;
        bit_idx_d    = bit_idx_q;
        div_cnt_d    = div_cnt_q;
        lat_cnt_d    = lat_cnt_q;
        shreg_d      = shreg_q;
        led_sclk_d   = led_sclk_q;
        led_sdi_d    = led_sdi_q;
        led_latch_d  = led_latch_q;
        busy_d       = busy_q;
        frame_drop_d = 1'b0;

        case (state_q)
            S_IDLE: begin
                led_sclk_d  = 1'b0;
                led_sdi_d   = 1'b0;
                led_latch_d = 1'b0;
                busy_d      = 1'b0;
                if (filter_end || pending_q) begin
                    wr_bank_d = ~wr_bank_q;
                    rd_bank_d = wr_bank_q;
                    zone_d    = '0;
                    pending_d = 1'b0;
                    busy_d    = 1'b1;
                    state_d   = S_LOAD;
                end
            end
            S_LOAD: begin
                shreg_d    = ram_rd;
                bit_idx_d  = BIT_MSB;
                div_cnt_d  = '0;
                led_sclk_d = 1'b0;
                led_sdi_d  = ram_rd[DATA_W-1];
                state_d    = S_SHIFT;
            end
            S_SHIFT: begin
                // led_sclk_q doubles as the phase flag: low phase first, then high.
                if (div_cnt_q == DIV_LAST) begin
                    div_cnt_d = '0;
                    if (!led_sclk_q) begin
                        led_sclk_d = 1'b1;
                    end else begin
                        led_sclk_d = 1'b0;
                        if (bit_idx_q == '0) begin
                            if (zone_q == ZONE_LAST) begin
                                led_latch_d = 1'b1;
                                lat_cnt_d   = '0;
                                state_d     = S_LATCH;
                            end else begin
                                zone_d  = zone_q + 1'b1;
                                state_d = S_LOAD;
                            end
                        end else begin
                            bit_idx_d = bit_idx_q - 1'b1;
                            led_sdi_d = shreg_q[bit_idx_q - 1'b1];
                        end
                    end
                end else begin
                    div_cnt_d = div_cnt_q + 1'b1;
                end
            end
            S_LATCH: begin
                led_sclk_d = 1'b0;
                if (lat_cnt_q == LAT_LAST) begin
                    led_latch_d = 1'b0;
                    state_d     = S_DONE;
                end else begin
                    lat_cnt_d = lat_cnt_q + 1'b1;
                end
            end
            S_DONE: begin
                led_latch_d = 1'b0;
                if (filter_end || pending_q) begin
                    wr_bank_d = ~wr_bank_q;
                    rd_bank_d = wr_bank_q;
                    zone_d    = '0;
                    pending_d = 1'b0;
                    state_d   = S_LOAD;
                end else begin
                    busy_d    = 1'b0;
                    led_sdi_d = 1'b0;
                    state_d   = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A frame end while shifting queues one frame; a second one is discarded.
        if (filter_end &&
            ((state_q == S_LOAD) || (state_q == S_SHIFT) || (state_q == S_LATCH))) begin
            if (pending_q) begin
                frame_drop_d = 1'b1;
            end else begin
                pending_d = 1'b1;
            end
        end
    end

    // State register with synchronous active-low reset.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst) begin
            state_q      <= S_IDLE;
            wr_bank_q    <= 1'b0;
            rd_bank_q    <= 1'b0;
            pending_q    <= 1'b0;
            zone_q       <= '0;
            bit_idx_q    <= '0;
            div_cnt_q    <= '0;
            lat_cnt_q    <= '0;
            shreg_q      <= '0;
            led_sclk_q   <= 1'b0;
            led_sdi_q    <= 1'b0;
            led_latch_q  <= 1'b0;
            busy_q       <= 1'b0;
            frame_drop_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_bank_q    <= wr_bank_d;
            rd_bank_q    <= rd_bank_d;
            pending_q    <= pending_d;
            zone_q       <= zone_d;
            bit_idx_q    <= bit_idx_d;
            div_cnt_q    <= div_cnt_d;
            lat_cnt_q    <= lat_cnt_d;
            shreg_q      <= shreg_d;
            led_sclk_q   <= led_sclk_d;
            led_sdi_q    <= led_sdi_d;
            led_latch_q  <= led_latch_d;
            busy_q       <= busy_d;
            frame_drop_q <= frame_drop_d;
        end
    end

    assign led_sclk   = led_sclk_q;
    assign led_sdi    = led_sdi_q;
    assign led_latch  = led_latch_q;
    assign busy       = busy_q;
    assign frame_drop = frame_drop_q;

endmodule
